// File: rtl/vga_pkg.sv
// Shared timing constants and helpers for the VGA display front end.
// Default values describe 640x480@60 with a 25 MHz pixel clock.
package vga_pkg;

    // Horizontal timing, in pixels
    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;

    // Vertical timing, in lines
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    // Derived totals: 800 x 525 with the defaults
    localparam int H_TOT_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOT_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    // Sync window bounds (inclusive): hsync [656,751], vsync [490,491]
    localparam int HS_FIRST_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int HS_LAST_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF - 1;
    localparam int VS_FIRST_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int VS_LAST_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF - 1;

    // Raster counters and pix_x/pix_y share this width; totals must stay below 1024
    localparam int CNT_W = 10;

    // Other defaults
    localparam int RD_LATENCY_DEF = 1;
    localparam int RGB_W_DEF      = 12;

    // Framebuffer address width needed to cover every visible pixel
    function automatic int fb_addr_w(input int h_active, input int v_active);
        return $clog2(h_active * v_active);
    endfunction

    // Per-pixel control flags carried alongside the framebuffer read
    typedef struct packed {
        logic hsync;        // inside hsync window (active-high internally)
        logic vsync;        // inside vsync window (active-high internally)
        logic active;       // visible pixel
        logic frame_start;  // position (0,0)
    } raster_flags_t;

    localparam int FLAGS_W = $bits(raster_flags_t);

endpackage

// File: rtl/vga_delay.sv
// Parameterised shift register with asynchronous reset to a supplied value.
// Used to hold raster control flags while the framebuffer read is in flight.
module vga_delay #(
    parameter int               WIDTH   = 4,
    parameter int               DEPTH   = 2,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    // tap[0] is the input, tap[DEPTH] the fully delayed output
    logic [WIDTH-1:0] tap [DEPTH+1];

    assign tap[0] = din;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic [WIDTH-1:0] q_reg;

            // One pipeline stage, cleared to the reset value
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    q_reg <= RST_VAL;
                end else begin
                    q_reg <= tap[gi];
                end
            end

            assign tap[gi+1] = q_reg;
        end
    endgenerate

    assign dout = tap[DEPTH];

endmodule

// File: rtl/vga_timing.sv
// VGA raster generator: counts the raster, issues linear framebuffer reads
// and re-aligns the returned pixel with sync/blank so all pin outputs change
// on the same edge. Counter-to-pin latency is RD_LATENCY+2 cycles.
module vga_timing
    import vga_pkg::*;
#(
    parameter int H_ACTIVE   = H_ACTIVE_DEF,
    parameter int H_FP       = H_FP_DEF,
    parameter int H_SYNC     = H_SYNC_DEF,
    parameter int H_BP       = H_BP_DEF,
    parameter int V_ACTIVE   = V_ACTIVE_DEF,
    parameter int V_FP       = V_FP_DEF,
    parameter int V_SYNC     = V_SYNC_DEF,
    parameter int V_BP       = V_BP_DEF,
    parameter bit SYNC_POL   = 1'b0,             // level while asserted; 0 = active-low
    parameter int RD_LATENCY = RD_LATENCY_DEF,   // 1..4
    parameter int RGB_W      = RGB_W_DEF,
    parameter int ADDR_W     = fb_addr_w(H_ACTIVE_DEF, V_ACTIVE_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [CNT_W-1:0]  pix_x,
    output logic [CNT_W-1:0]  pix_y,
    input  logic [RGB_W-1:0]  rgb_in,
    output logic              hsync,
    output logic              vsync,
    output logic              video_on,
    output logic [RGB_W-1:0]  rgb_out,
    output logic              frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter-width copies of the timing bounds, so compares stay width-matched
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Flags wait one cycle for the request register plus RD_LATENCY for the read
    localparam int FLAG_DEPTH = RD_LATENCY + 1;

    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] vcnt;

    logic          req_active;
    logic          req_origin;
    raster_flags_t flags_req;
    raster_flags_t flags_aligned;

    // Raster position: hcnt every cycle, vcnt on hcnt wrap, both wrap at their totals
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (hcnt == H_LAST) begin
            hcnt <= '0;
            vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
        end else begin
            hcnt <= hcnt + 1'b1;
        end
    end

    // Classify the position currently held in the counters
    always_comb begin
        req_active            = (hcnt < H_VIS) && (vcnt < V_VIS);
        req_origin            = (hcnt == '0) && (vcnt == '0);
        flags_req             = '0;
        flags_req.hsync       = (hcnt >= HS_FIRST) && (hcnt <= HS_LAST);
        flags_req.vsync       = (vcnt >= VS_FIRST) && (vcnt <= VS_LAST);
        flags_req.active      = req_active;
        flags_req.frame_start = req_origin;
    end

    // Request stage: linear address tracks the raster without a multiplier.
    // It holds across blanking, so the next line resumes at the right address,
    // and is forced to 0 at (0,0) so a frame can never run past the last pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fb_rd_en <= 1'b0;
            fb_addr  <= '0;
            pix_x    <= '0;
            pix_y    <= '0;
        end else begin
            fb_rd_en <= req_active;
            pix_x    <= hcnt;
            pix_y    <= vcnt;
            if (req_active) begin
                fb_addr <= req_origin ? '0 : fb_addr + 1'b1;
            end
        end
    end

    // Carry control flags alongside the in-flight read
    vga_delay #(
        .WIDTH   (FLAGS_W),
        .DEPTH   (FLAG_DEPTH),
        .RST_VAL ('0)
    ) u_flag_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (flags_req),
        .dout (flags_aligned)
    );

    // Output stage: every pin signal registered on the same edge, no skew
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            video_on    <= 1'b0;
            frame_start <= 1'b0;
            rgb_out     <= '0;
        end else begin
            hsync       <= flags_aligned.hsync ? SYNC_POL : ~SYNC_POL;
            vsync       <= flags_aligned.vsync ? SYNC_POL : ~SYNC_POL;
            video_on    <= flags_aligned.active;
            frame_start <= flags_aligned.frame_start;
            rgb_out     <= flags_aligned.active ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing.sv
// Self-checking bench for vga_timing. Two instances with reduced raster
// sizes (latency 1 / active-low sync and latency 3 / active-high sync) share
// clock and reset. Expected outputs come from the cycle count since reset
// release using the raster rules directly.
module tb_vga_timing;
    import vga_pkg::*;

    localparam int HA  = 16;
    localparam int HFP = 2;
    localparam int HSW = 3;
    localparam int HBP = 3;
    localparam int VA  = 8;
    localparam int VFP = 1;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int HT  = HA + HFP + HSW + HBP;
    localparam int VT  = VA + VFP + VSW + VBP;
    localparam int FT  = HT * VT;
    localparam int AW  = fb_addr_w(HA, VA);
    localparam int LA  = 1;
    localparam int LB  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        fff = 1'b0;
    logic [11:0] mem [HA*VA];

    logic          rd_en_a, rd_en_b;
    logic [AW-1:0] addr_a, addr_b;
    logic [9:0]    px_a, py_a, px_b, py_b;
    logic [11:0]   rgb_in_a, rgb_in_b, rgb_a, rgb_b;
    logic          hs_a, vs_a, von_a, fs_a;
    logic          hs_b, vs_b, von_b, fs_b;

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b0), .RD_LATENCY(LA), .RGB_W(12), .ADDR_W(AW)
    ) dut_a (
        .clk(clk), .rst(rst), .fb_rd_en(rd_en_a), .fb_addr(addr_a),
        .pix_x(px_a), .pix_y(py_a), .rgb_in(rgb_in_a), .hsync(hs_a),
        .vsync(vs_a), .video_on(von_a), .rgb_out(rgb_a), .frame_start(fs_a)
    );

    vga_timing #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .SYNC_POL(1'b1), .RD_LATENCY(LB), .RGB_W(12), .ADDR_W(AW)
    ) dut_b (
        .clk(clk), .rst(rst), .fb_rd_en(rd_en_b), .fb_addr(addr_b),
        .pix_x(px_b), .pix_y(py_b), .rgb_in(rgb_in_b), .hsync(hs_b),
        .vsync(vs_b), .video_on(von_b), .rgb_out(rgb_b), .frame_start(fs_b)
    );

    // Framebuffer memories with fixed read latency
    logic [11:0] pipe_a;
    logic [11:0] pipe_b [LB];
    always @(posedge clk) begin
        pipe_a    <= fff ? 12'hFFF : mem[addr_a];
        pipe_b[0] <= fff ? 12'hFFF : mem[addr_b];
        for (int i = 1; i < LB; i++) pipe_b[i] <= pipe_b[i-1];
    end
    assign rgb_in_a = pipe_a;
    assign rgb_in_b = pipe_b[LB-1];

    int k = 0;          // clock edges since reset release
    int n_checks = 0;
    int n_pass = 0;
    int fs_cnt_a, fs_first_a, fs_last_a;
    int fs_cnt_b, fs_first_b, fs_last_b;
    int max_addr_a, nz_a, von_cnt_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, exp);
    endtask

    function automatic logic [11:0] pix_data(input int addr);
        return fff ? 12'hFFF : mem[addr];
    endfunction

    task automatic check_dut(input string nm, input int lat, input bit pol,
                             input logic en, input logic [AW-1:0] addr,
                             input logic [9:0] x, input logic [9:0] y,
                             input logic hs, input logic vs, input logic von,
                             input logic fs, input logic [11:0] rgb);
        int p, ox, oy;
        logic e_en, e_hs, e_vs, e_von, e_fs;
        int e_addr, e_x, e_y;
        logic [11:0] e_rgb;
        // Request stage shows the position the counters held one edge earlier
        e_en = 1'b0; e_addr = 0; e_x = 0; e_y = 0;
        if (k >= 1) begin
            p   = (k - 1) % FT;
            e_x = p % HT;
            e_y = p / HT;
            e_en = (e_x < HA) && (e_y < VA);
            if (e_y >= VA)      e_addr = HA * VA - 1;
            else if (e_x >= HA) e_addr = e_y * HA + HA - 1;
            else                e_addr = e_y * HA + e_x;
        end
        // Pin stage lags the counters by lat+2 edges
        e_hs = !pol; e_vs = !pol; e_von = 1'b0; e_fs = 1'b0; e_rgb = 12'h000;
        if (k >= lat + 2) begin
            p  = (k - lat - 2) % FT;
            ox = p % HT;
            oy = p / HT;
            e_von = (ox < HA) && (oy < VA);
            e_hs  = (ox >= HA + HFP && ox < HA + HFP + HSW) ? pol : !pol;
            e_vs  = (oy >= VA + VFP && oy < VA + VFP + VSW) ? pol : !pol;
            e_fs  = (p == 0);
            e_rgb = e_von ? pix_data(oy * HA + ox) : 12'h000;
        end
        chk({nm, ".fb_rd_en"},    32'(en),   32'(e_en));
        chk({nm, ".fb_addr"},     32'(addr), e_addr);
        chk({nm, ".pix_x"},       32'(x),    e_x);
        chk({nm, ".pix_y"},       32'(y),    e_y);
        chk({nm, ".hsync"},       32'(hs),   32'(e_hs));
        chk({nm, ".vsync"},       32'(vs),   32'(e_vs));
        chk({nm, ".video_on"},    32'(von),  32'(e_von));
        chk({nm, ".frame_start"}, 32'(fs),   32'(e_fs));
        chk({nm, ".rgb_out"},     32'(rgb),  32'(e_rgb));
    endtask

    task automatic check_all();
        check_dut("a", LA, 1'b0, rd_en_a, addr_a, px_a, py_a, hs_a, vs_a, von_a, fs_a, rgb_a);
        check_dut("b", LB, 1'b1, rd_en_b, addr_b, px_b, py_b, hs_b, vs_b, von_b, fs_b, rgb_b);
    endtask

    task automatic clear_stats();
        fs_cnt_a = 0; fs_first_a = -1; fs_last_a = -1;
        fs_cnt_b = 0; fs_first_b = -1; fs_last_b = -1;
        max_addr_a = 0; nz_a = 0; von_cnt_a = 0;
    endtask

    // One clock: advance, then sample on the falling edge
    task automatic step();
        @(posedge clk);
        if (rst) k = 0; else k++;
        @(negedge clk);
        check_all();
        if (fs_a) begin fs_cnt_a++; if (fs_first_a < 0) fs_first_a = k; fs_last_a = k; end
        if (fs_b) begin fs_cnt_b++; if (fs_first_b < 0) fs_first_b = k; fs_last_b = k; end
        if (rd_en_a && int'(addr_a) > max_addr_a) max_addr_a = int'(addr_a);
        if (rgb_a != 12'h000) nz_a++;
        if (von_a) von_cnt_a++;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < HA * VA; i++) mem[i] = 12'($urandom);
    endtask

    // Called on a falling edge: assert reset, check it acts without a clock edge
    task automatic do_reset(input int cycles, input logic new_fff);
        rst = 1'b1;
        #1;
        k = 0;
        check_all();
        fill_mem();
        fff = new_fff;
        repeat (cycles) step();
        rst = 1'b0;
        clear_stats();
    endtask

    initial begin
        fill_mem();
        clear_stats();
        // Power-up reset
        repeat (3) step();
        rst = 1'b0;
        clear_stats();

        // Two full frames with random framebuffer contents
        repeat (2 * FT) step();
        chk("fs_count_a",  fs_cnt_a, 2);
        chk("fs_period_a", fs_last_a - fs_first_a, FT);
        chk("fs_count_b",  fs_cnt_b, 2);
        chk("fs_period_b", fs_last_b - fs_first_b, FT);
        chk("max_addr_a",  max_addr_a, HA * VA - 1);

        // Reset mid-frame with the counters at hcnt=10, vcnt=5
        repeat ((5 * HT + 10 - (k % FT) + FT) % FT) step();
        do_reset(3, 1'b0);
        repeat (FT) step();
        chk("fs_after_rst_a", fs_first_a, LA + 2);
        chk("fs_after_rst_b", fs_first_b, LB + 2);

        // Constant full-white framebuffer: only visible pixels reach the pins
        do_reset(2, 1'b1);
        repeat (FT) step();
        chk("nonzero_pix_a", nz_a, HA * VA);
        chk("video_on_a",    von_cnt_a, HA * VA);

        // Random reset points, durations and data modes
        for (int r = 0; r < 4; r++) begin
            repeat ($urandom_range(30, 400)) step();
            do_reset($urandom_range(1, 4), 1'($urandom_range(0, 1)));
        end
        repeat (FT + 10) step();
        chk("rand_fs_first_a", fs_first_a, LA + 2);
        chk("rand_fs_first_b", fs_first_b, LB + 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
